// File: rtl/tpu_sequencer.sv
// Instruction sequencer for the systolic-array datapath (optional busy counter: TPU_SEQ_PERF_CNT_EN).
// First enable one cycle after acceptance; instr_ready only in IDLE, so an instruction stalls while one runs.
module tpu_sequencer #(
  parameter int ROWS    = 16,
  parameter int ADDR_W  = 8,
  parameter int LEN_W   = 8,
  parameter int MMU_LAT = 2*ROWS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] addra,
  output logic [ADDR_W-1:0] addrb,
  output logic              ub_wea,
  output logic              wb_wea,
  output logic              ub_enb,
  output logic              wb_enb,
  output logic              dfifo_en,
  output logic              wfifo_en,
  output logic              mmu_wen,
  output logic              acc_en,
  output logic [31:0]       perf_busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_LOADW = 3'd2;
  localparam logic [2:0] S_FEED  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_WDATA = 4'd1;
  localparam logic [3:0] OP_WWGT  = 4'd2;
  localparam logic [3:0] OP_LOADW = 4'd3;
  localparam logic [3:0] OP_MMUL  = 4'd4;

  logic [2:0]        state;
  logic [31:0]       cnt;
  logic [LEN_W-1:0]  len_q;
  logic [ADDR_W-1:0] addr;
  logic              wsel;
  logic              rdy_q;
  logic              done_q;
  logic              err_q;
  logic              wb_enb_d;
  logic              ub_enb_d;

  logic [3:0]        op;
  logic [LEN_W-1:0]  len_in;
  logic [ADDR_W-1:0] base_in;
  logic              accept;
  logic [31:0]       len32;
  logic              unused_instr;

  assign op           = instr[31:28];
  assign len_in       = instr[LEN_W-1:0];
  assign base_in      = instr[16 +: ADDR_W];
  assign unused_instr = ^instr;
  assign accept       = instr_valid & instr_ready;
  assign len32        = 32'(len_q);

  // rdy_q keeps instr_ready low until the first edge after reset release
  assign instr_ready = rdy_q && (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign done        = done_q;
  assign err         = err_q;
  assign ub_wea      = (state == S_WRITE) && !wsel;
  assign wb_wea      = (state == S_WRITE) && wsel;
  assign wb_enb      = (state == S_LOADW) && (cnt < 32'(ROWS));
  assign ub_enb      = (state == S_FEED);
  assign wfifo_en    = wb_enb_d;
  assign mmu_wen     = wb_enb_d;
  assign dfifo_en    = ub_enb_d;
  assign addra       = (state == S_WRITE) ? addr : '0;
  assign addrb       = (wb_enb || ub_enb) ? addr : '0;
  // cnt runs across FEED and DRAIN, so acc_en may overlap the tail of FEED for long len
  assign acc_en      = ((state == S_FEED) || (state == S_DRAIN)) &&
                       (cnt >= 32'(MMU_LAT + 1)) && (cnt <= 32'(MMU_LAT) + len32);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      len_q    <= '0;
      addr     <= '0;
      wsel     <= 1'b0;
      rdy_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      wb_enb_d <= 1'b0;
      ub_enb_d <= 1'b0;
    end else begin
      rdy_q    <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      wb_enb_d <= wb_enb;
      ub_enb_d <= ub_enb;
      case (state)
        S_IDLE: begin
          if (accept) begin
            addr  <= base_in;
            cnt   <= '0;
            len_q <= len_in;
            case (op)
              OP_NOP: done_q <= 1'b1;
              OP_WDATA, OP_WWGT: begin
                wsel <= (op == OP_WWGT);
                if (len_in == '0) done_q <= 1'b1;
                else              state  <= S_WRITE;
              end
              OP_LOADW: state <= S_LOADW;
              OP_MMUL: begin
                if (len_in == '0) done_q <= 1'b1;
                else              state  <= S_FEED;
              end
              default: err_q <= 1'b1;
            endcase
          end
        end
        S_WRITE: begin
          addr <= addr + 1'b1;
          cnt  <= cnt + 32'd1;
          if (cnt == len32 - 32'd1) begin
            state  <= S_IDLE;
            done_q <= 1'b1;
          end
        end
        S_LOADW: begin
          if (wb_enb) addr <= addr + 1'b1;
          cnt <= cnt + 32'd1;
          // one extra cycle lets the delayed wfifo/mmu enables finish
          if (cnt == 32'(ROWS)) begin
            state  <= S_IDLE;
            done_q <= 1'b1;
          end
        end
        S_FEED: begin
          addr <= addr + 1'b1;
          cnt  <= cnt + 32'd1;
          if (cnt == len32 - 32'd1) state <= S_DRAIN;
        end
        S_DRAIN: begin
          cnt <= cnt + 32'd1;
          if (cnt == 32'(MMU_LAT) + len32) begin
            state  <= S_IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef TPU_SEQ_PERF_CNT_EN
  logic [31:0] perf_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 perf_q <= '0;
    else if (busy && perf_q != '1) perf_q <= perf_q + 32'd1;
  end
  assign perf_busy = perf_q;
`else
  assign perf_busy = '0;
`endif

endmodule
